dual_port_dmem: RTL
===================

DUAL_PORT_DMEM -- requirements
Module: dual_port_dmem

Interface
REQ-001: Parameter ADDR_W, default 9, word-address width.
REQ-002: Parameter DATA_W, default 16, data word width.
REQ-003: Parameter DEPTH, default 512, number of words (2**ADDR_W).
REQ-004: Port clk  input  1  single clock; all state changes on rising edge.
REQ-005: Port rst  input  1  reset, asynchronous, active-low.
REQ-006: Port p0_DM_maddr  input  ADDR_W  pipeline-0 word address.
REQ-007: Port p0_DM_wdata  input  DATA_W  pipeline-0 write data.
REQ-008: Port p0_DM_write_mem  input  1  pipeline-0 write enable.
REQ-009: Port p0_DM_rdata  output  DATA_W  pipeline-0 read data, registered.
REQ-010: Ports p1_DM_maddr, p1_DM_wdata, p1_DM_write_mem, p1_DM_rdata SHALL mirror REQ-006..009 for pipeline 1.
REQ-011: Port ready  output  1  high when the memory accepts accesses (RUN state).
REQ-012: Port collision  output  1  one-cycle pulse flagging a same-address dual write.

Function
REQ-013: FSM states SHALL be CLEAR and RUN; reset forces CLEAR with clear_ptr=0.
REQ-014: In CLEAR, each cycle SHALL write 0 to mem[clear_ptr] and increment clear_ptr; at clear_ptr=DEPTH-1, transition to RUN on the next edge (CLEAR lasts exactly DEPTH cycles).
REQ-015: In CLEAR, both write enables SHALL be ignored, both rdata SHALL stay 0, and ready SHALL be 0.
REQ-016: In RUN, ready SHALL be 1; each port SHALL read every cycle with 1-cycle latency: pX_DM_rdata at edge N+1 = contents of pX_DM_maddr sampled at edge N.
REQ-017: A write SHALL commit mem[addr]=wdata on the sampling edge.
REQ-018: Read-during-write is write-first: if either port writes the address a port reads in the same cycle, that port's rdata SHALL return the new data.
REQ-019: If both ports write the same address in one cycle, p1 data SHALL be stored and forwarded (p1 priority, matching the register file rule), and collision SHALL pulse high the following cycle only.
REQ-020: If both ports write different addresses, both writes SHALL commit; collision stays 0.
REQ-021: Both ports reading the same address SHALL both return identical data; no collision pulse.
REQ-022: Addresses are full-width; no wrap or out-of-range case exists (DEPTH = 2**ADDR_W).

Reset
REQ-023: Asserting rst at any time SHALL immediately set p0_DM_rdata=0, p1_DM_rdata=0, ready=0, collision=0, state=CLEAR, clear_ptr=0.
REQ-024: Reset mid-RUN SHALL discard in-flight writes of that cycle and re-clear all of memory after deassertion.
REQ-025: Memory array contents are not reset asynchronously; zeroing occurs only via CLEAR.

Structure
REQ-026: Package dmem_pkg SHALL hold ADDR_W/DATA_W/DEPTH defaults and the state enum type (CLEAR, RUN).
REQ-027: Sub-module dmem_clear_fsm SHALL own state, clear_ptr and ready; the top holds the array, write arbitration and read/bypass registers.

Verification
REQ-028: Deassert rst, count cycles -> ready rises exactly 512 cycles later; then p0 read 0x1FF -> rdata 0x0000 next cycle.
REQ-029: RUN, p0 write 0x00A=0xBEEF, next cycle p1 read 0x00A -> p1_DM_rdata=0xBEEF one cycle later.
REQ-030: Same cycle p0 write 0x010=0x1111, p1 write 0x010=0x2222 -> both rdata 0x2222, collision high one cycle, later read of 0x010 = 0x2222.
REQ-031: Same cycle p0 write 0x020=0x1234, p1 read 0x020 -> p1_DM_rdata=0x1234 next cycle.
REQ-032: During CLEAR p0 write 0x005=0xFFFF -> after ready, read 0x005 = 0x0000.
REQ-033: Write 0x030=0xAAAA in RUN, pulse rst low -> ready/rdata 0 immediately, ready returns after 512 cycles, read 0x030 = 0x0000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared defaults and FSM state type for the dual-port data memory.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/dmem_clear_fsm.sv
// Power-up/reset sequencer: sweeps every word to zero once, then grants access.
module dmem_clear_fsm
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clear_en,
    output logic [ADDR_W-1:0] clear_ptr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    dmem_state_t       state;
    dmem_state_t       state_next;
    logic [ADDR_W-1:0] ptr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_next;
            clear_ptr <= ptr_next;
        end
    end

    // One word is zeroed per cycle; the last word's edge also moves to RUN.
    always_comb begin
        state_next = state;
        ptr_next   = clear_ptr;
        clear_en   = 1'b0;
        ready      = 1'b0;
        case (state)
            CLEAR: begin
                clear_en = 1'b1;
                if (clear_ptr == LAST_PTR) begin
                    state_next = RUN;
                    ptr_next   = '0;
                end else begin
                    ptr_next = clear_ptr + ADDR_W'(1);
                end
            end
            RUN: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dual_port_dmem.sv
// Two-pipeline data memory: write-first registered reads, p1 wins same-address
// write conflicts, and the array is zeroed by a sweep after every reset.
module dual_port_dmem
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_DM_maddr,
    input  logic [DATA_W-1:0] p0_DM_wdata,
    input  logic              p0_DM_write_mem,
    output logic [DATA_W-1:0] p0_DM_rdata,
    input  logic [ADDR_W-1:0] p1_DM_maddr,
    input  logic [DATA_W-1:0] p1_DM_wdata,
    input  logic              p1_DM_write_mem,
    output logic [DATA_W-1:0] p1_DM_rdata,
    output logic              ready,
    output logic              collision
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clear_en;
    logic [ADDR_W-1:0] clear_ptr;
    logic              same_addr;
    logic              we0;
    logic              we1;
    logic              collision_next;
    logic [DATA_W-1:0] rd0_next;
    logic [DATA_W-1:0] rd1_next;

    dmem_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_en  (clear_en),
        .clear_ptr (clear_ptr),
        .ready     (ready)
    );

    // Write arbitration: p0 is dropped when p1 targets the same word.
    always_comb begin
        same_addr      = (p0_DM_maddr == p1_DM_maddr);
        we1            = ready && p1_DM_write_mem;
        we0            = ready && p0_DM_write_mem && !(p1_DM_write_mem && same_addr);
        collision_next = ready && p0_DM_write_mem && p1_DM_write_mem && same_addr;
    end

    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clear_ptr] <= '0;
        end
        if (we0) begin
            mem[p0_DM_maddr] <= p0_DM_wdata;
        end
        if (we1) begin
            mem[p1_DM_maddr] <= p1_DM_wdata;
        end
    end

    // Write-first read: same-cycle write data bypasses the array, p1 first.
    always_comb begin
        rd0_next = '0;
        rd1_next = '0;
        if (ready) begin
            if (we1 && (p1_DM_maddr == p0_DM_maddr)) begin
                rd0_next = p1_DM_wdata;
            end else if (we0) begin
                rd0_next = p0_DM_wdata;
            end else begin
                rd0_next = mem[p0_DM_maddr];
            end

            if (we1) begin
                rd1_next = p1_DM_wdata;
            end else if (we0 && (p0_DM_maddr == p1_DM_maddr)) begin
                rd1_next = p0_DM_wdata;
            end else begin
                rd1_next = mem[p1_DM_maddr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_DM_rdata <= '0;
            p1_DM_rdata <= '0;
            collision   <= 1'b0;
        end else begin
            p0_DM_rdata <= rd0_next;
            p1_DM_rdata <= rd1_next;
            collision   <= collision_next;
        end
    end

endmodule
